// File: rtl/plane_bus_writer_if.sv
// Strobed byte bus between the plane bus writer and a plane controller.
// The receiver captures dataOut and rs on the falling edge of dataEn.
interface plane_bus_writer_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] dataOut;
  logic               dataEn;
  logic               rs;

  modport master (output dataOut, dataEn, rs);
  modport slave  (input  dataOut, dataEn, rs);
endinterface

// File: rtl/plane_bus_writer.sv
// Plane bus writer: streams a shadow brightness buffer, or a single clear
// command, to a plane controller as SETUP/HIGH/HOLD strobed transfers.
module plane_bus_writer #(
  parameter int OUT_NUM    = 64,
  parameter int D_WIDTH    = 8,
  parameter int C_WIDTH    = 4,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(OUT_NUM)-1:0] wr_addr,
  input  logic [C_WIDTH-1:0]         wr_data,
  input  logic                       start,
  input  logic                       clear_req,
  plane_bus_writer_if.master         bus,
  output logic                       busy,
  output logic                       done
);
  localparam int AW   = $clog2(OUT_NUM);
  localparam int SW   = $clog2(OUT_NUM + 2);
  localparam int MAXC = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(OUT_NUM + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

  logic [C_WIDTH-1:0] buffer [OUT_NUM];

  state_t             state, stateNext;
  logic [SW-1:0]      step, stepNext, stepInc;
  logic [CW-1:0]      cnt, cntNext;
  logic               isClear, clrNext;
  logic [D_WIDTH-1:0] dataOutQ, dataNext, nextByte;
  logic               rsQ, rsNext;
  logic               enQ, enNext;
  logic               busyQ, busyNext;
  logic               doneQ, doneNext;
  logic [AW-1:0]      bufIdx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < OUT_NUM; i++) buffer[AW'(i)] <= '0;
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // The byte for the following step is fetched as HOLD hands over to SETUP,
  // so a write landing on that same edge is not yet visible.
  assign stepInc  = step + SW'(1);
  assign bufIdx   = (stepInc >= SW'(2)) ? AW'(stepInc - SW'(2)) : '0;
  assign nextByte = (stepInc == SW'(1)) ? D_WIDTH'(8'h80) : D_WIDTH'(buffer[bufIdx]);

  always_comb begin
    stateNext = state;
    stepNext  = step;
    cntNext   = cnt;
    clrNext   = isClear;
    dataNext  = dataOutQ;
    rsNext    = rsQ;
    enNext    = 1'b0;
    busyNext  = busyQ;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          stateNext = SETUP;
          clrNext   = 1'b1;
          stepNext  = '0;
          dataNext  = D_WIDTH'(8'h01);
          rsNext    = 1'b1;
          busyNext  = 1'b1;
        end else if (start) begin
          stateNext = SETUP;
          clrNext   = 1'b0;
          stepNext  = '0;
          dataNext  = D_WIDTH'(8'h06);
          rsNext    = 1'b1;
          busyNext  = 1'b1;
        end
      end
      SETUP: begin
        stateNext = HIGH;
        enNext    = 1'b1;
        cntNext   = '0;
      end
      HIGH: begin
        if (cnt == CW'(EN_CYCLES - 1)) begin
          stateNext = HOLD;
          cntNext   = '0;
        end else begin
          enNext  = 1'b1;
          cntNext = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cntNext = '0;
          if (isClear || step == LAST_STEP) begin
            stateNext = IDLE;
            stepNext  = '0;
            clrNext   = 1'b0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            stateNext = SETUP;
            stepNext  = stepInc;
            dataNext  = nextByte;
            rsNext    = (stepInc < SW'(2));
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      isClear  <= 1'b0;
      dataOutQ <= '0;
      rsQ      <= 1'b0;
      enQ      <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      state    <= stateNext;
      step     <= stepNext;
      cnt      <= cntNext;
      isClear  <= clrNext;
      dataOutQ <= dataNext;
      rsQ      <= rsNext;
      enQ      <= enNext;
      busyQ    <= busyNext;
      doneQ    <= doneNext;
    end
  end

  assign bus.dataOut = dataOutQ;
  assign bus.dataEn  = enQ;
  assign bus.rs      = rsQ;
  assign busy        = busyQ;
  assign done        = doneQ;
endmodule

// File: tb/tb_plane_bus_writer.sv
// Bench for plane_bus_writer: a bus monitor acting as the plane controller
// records every strobe and is compared with a transfer-list model.
module tb_plane_bus_writer;
  localparam int N     = 64;
  localparam int NB    = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wrEnA = 1'b0, startA = 1'b0, clearA = 1'b0;
  logic [5:0] wrAddrA = '0;
  logic [3:0] wrDataA = '0;
  logic busyA, doneA;
  logic wrEnB = 1'b0, startB = 1'b0, clearB = 1'b0;
  logic [1:0] wrAddrB = '0;
  logic [3:0] wrDataB = '0;
  logic busyB, doneB;

  plane_bus_writer_if #(.D_WIDTH(8)) busA ();
  plane_bus_writer_if #(.D_WIDTH(8)) busB ();

  always #5 clk = ~clk;

  plane_bus_writer dutA (
    .clk(clk), .reset(reset), .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_data(wrDataA),
    .start(startA), .clear_req(clearA), .bus(busA), .busy(busyA), .done(doneA)
  );

  plane_bus_writer #(.OUT_NUM(NB), .EN_CYCLES(1), .GAP_CYCLES(GAP_B)) dutB (
    .clk(clk), .reset(reset), .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB),
    .start(startB), .clear_req(clearB), .bus(busB), .busy(busyB), .done(doneB)
  );

  int testCount = 0;
  int failCount = 0;
  logic [3:0] shadowA [N];
  logic [3:0] shadowB [NB];
  logic monClear = 1'b0;

  // Plane controller model for dutA: strobe capture, timing checks, memory.
  logic [8:0] capA[$];
  int lenA[$];
  int violA, busyCyA, doneCntA, runA, holdA;
  logic [8:0] holdValA, prevA;
  logic prevEnA;
  logic [7:0] pmem [N];
  logic [5:0] paddr;

  always @(negedge clk) begin
    if (monClear) begin
      capA.delete(); lenA.delete();
      violA = 0; busyCyA = 0; doneCntA = 0; runA = 0; holdA = 0;
      prevA = {busA.rs, busA.dataOut}; prevEnA = busA.dataEn;
      paddr = '0;
      for (int i = 0; i < N; i++) pmem[6'(i)] = 8'hEE;
    end else begin
      if (busyA) busyCyA++;
      if (doneA) doneCntA++;
      if (busA.dataEn && {busA.rs, busA.dataOut} !== prevA) violA++;
      if (busA.dataEn) runA++;
      if (prevEnA && !busA.dataEn) begin
        capA.push_back(prevA); lenA.push_back(runA); runA = 0;
        holdValA = prevA; holdA = GAP_A;
        if (prevA[8]) begin
          if (prevA[7:0] == 8'h01) begin
            for (int i = 0; i < N; i++) pmem[6'(i)] = 8'h00;
            paddr = '0;
          end else if (prevA[7]) paddr = prevA[5:0];
        end else begin
          pmem[paddr] = prevA[7:0];
          paddr = paddr + 6'd1;
        end
      end
      if (holdA > 0) begin
        if (busA.dataEn || {busA.rs, busA.dataOut} !== holdValA) violA++;
        holdA--;
      end
      prevA = {busA.rs, busA.dataOut}; prevEnA = busA.dataEn;
    end
  end

  logic [8:0] capB[$];
  int lenB[$];
  int violB, busyCyB, doneCntB, runB, holdB;
  logic [8:0] holdValB, prevB;
  logic prevEnB;

  always @(negedge clk) begin
    if (monClear) begin
      capB.delete(); lenB.delete();
      violB = 0; busyCyB = 0; doneCntB = 0; runB = 0; holdB = 0;
      prevB = {busB.rs, busB.dataOut}; prevEnB = busB.dataEn;
    end else begin
      if (busyB) busyCyB++;
      if (doneB) doneCntB++;
      if (busB.dataEn && {busB.rs, busB.dataOut} !== prevB) violB++;
      if (busB.dataEn) runB++;
      if (prevEnB && !busB.dataEn) begin
        capB.push_back(prevB); lenB.push_back(runB); runB = 0;
        holdValB = prevB; holdB = GAP_B;
      end
      if (holdB > 0) begin
        if (busB.dataEn || {busB.rs, busB.dataOut} !== holdValB) violB++;
        holdB--;
      end
      prevB = {busB.rs, busB.dataOut}; prevEnB = busB.dataEn;
    end
  end

  // Expected {rs, data} of plane transfer k.
  function automatic logic [8:0] expA(input int k);
    if (k == 0) return {1'b1, 8'h06};
    if (k == 1) return {1'b1, 8'h80};
    return {1'b0, 4'h0, shadowA[6'(k - 2)]};
  endfunction

  function automatic logic [8:0] expB(input int k);
    if (k == 0) return {1'b1, 8'h06};
    if (k == 1) return {1'b1, 8'h80};
    return {1'b0, 4'h0, shadowB[2'(k - 2)]};
  endfunction

  task automatic clear_mon;
    @(negedge clk); #1 monClear = 1'b1;
    @(negedge clk); #1 monClear = 1'b0;
  endtask

  task automatic pulse_a(input logic s, input logic c);
    @(posedge clk); #1 startA = s; clearA = c;
    @(posedge clk); #1 startA = 1'b0; clearA = 1'b0;
  endtask

  task automatic write_a(input int a, input logic [3:0] d);
    @(posedge clk); #1 wrEnA = 1'b1; wrAddrA = 6'(a); wrDataA = d;
    @(posedge clk); #1 wrEnA = 1'b0;
    shadowA[6'(a)] = d;
  endtask

  task automatic wait_done_a(input int budget, input string name);
    int d0 = doneCntA;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (doneCntA != d0) break;
    end
    testCount++;
    if (doneCntA == d0) begin
      failCount++; $display("FAIL %s_done: no done after %0d cycles", name, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    testCount++;
    if ({busA.dataOut, busA.dataEn, busA.rs, busyA, doneA} !== 12'h000) begin
      failCount++; $display("FAIL reset_outputs_a: got %h want 000", {busA.dataOut, busA.dataEn, busA.rs, busyA, doneA});
    end
    testCount++;
    if ({busB.dataOut, busB.dataEn, busB.rs, busyB, doneB} !== 12'h000) begin
      failCount++; $display("FAIL reset_outputs_b: got %h want 000", {busB.dataOut, busB.dataEn, busB.rs, busyB, doneB});
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < N; i++) shadowA[6'(i)] = 4'h0;
    for (int i = 0; i < NB; i++) shadowB[2'(i)] = 4'h0;
    clear_mon;
    repeat (3) @(negedge clk);
    testCount++;
    if (busyA !== 1'b0 || busA.dataEn !== 1'b0) begin
      failCount++; $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busyA, busA.dataEn);
    end
  endtask

  task automatic test_plane_zero;
    clear_mon; pulse_a(1'b1, 1'b0); wait_done_a(400, "plane_zero");
    testCount++;
    if (capA.size() != N + 2) begin
      failCount++; $display("FAIL plane_zero_count: got %0d want %0d", capA.size(), N + 2);
    end
    for (int k = 0; k < capA.size() && k < N + 2; k++) begin
      testCount++;
      if (capA[k] !== expA(k)) begin
        failCount++; $display("FAIL plane_zero_xfer%0d: got %h want %h", k, capA[k], expA(k));
      end
      testCount++;
      if (lenA[k] != 2) begin
        failCount++; $display("FAIL plane_zero_enlen%0d: got %0d want 2", k, lenA[k]);
      end
    end
    testCount++;
    if (violA != 0) begin failCount++; $display("FAIL plane_zero_stable: got %0d violations want 0", violA); end
    testCount++;
    if (busyCyA != 330) begin failCount++; $display("FAIL plane_zero_busy: got %0d want 330", busyCyA); end
    testCount++;
    if (doneCntA != 1) begin failCount++; $display("FAIL plane_zero_done: got %0d want 1", doneCntA); end
  endtask

  task automatic test_plane_pattern;
    for (int i = 0; i < N; i++) write_a(i, 4'(i % 16));
    clear_mon; pulse_a(1'b1, 1'b0); wait_done_a(400, "pattern");
    for (int k = 0; k < capA.size() && k < N + 2; k++) begin
      testCount++;
      if (capA[k] !== expA(k)) begin
        failCount++; $display("FAIL pattern_xfer%0d: got %h want %h", k, capA[k], expA(k));
      end
    end
    for (int i = 0; i < N; i++) begin
      testCount++;
      if (pmem[6'(i)] !== 8'(i % 16)) begin
        failCount++; $display("FAIL pattern_mem%0d: got %h want %h", i, pmem[6'(i)], 8'(i % 16));
      end
    end
  endtask

  task automatic test_random_plane;
    for (int i = 0; i < N; i++) write_a(i, 4'($urandom_range(0, 15)));
    repeat ($urandom_range(0, 7)) @(posedge clk);
    clear_mon; pulse_a(1'b1, 1'b0); wait_done_a(400, "random");
    testCount++;
    if (capA.size() != N + 2) begin
      failCount++; $display("FAIL random_count: got %0d want %0d", capA.size(), N + 2);
    end
    for (int i = 0; i < N; i++) begin
      testCount++;
      if (pmem[6'(i)] !== {4'h0, shadowA[6'(i)]}) begin
        failCount++; $display("FAIL random_mem%0d: got %h want %h", i, pmem[6'(i)], shadowA[6'(i)]);
      end
    end
  endtask

  task automatic test_clear;
    clear_mon; pulse_a(1'b0, 1'b1); wait_done_a(50, "clear");
    testCount++;
    if (capA.size() != 1) begin failCount++; $display("FAIL clear_count: got %0d want 1", capA.size()); end
    else begin
      testCount++;
      if (capA[0] !== 9'h101) begin failCount++; $display("FAIL clear_xfer: got %h want 101", capA[0]); end
      testCount++;
      if (lenA[0] != 2) begin failCount++; $display("FAIL clear_enlen: got %0d want 2", lenA[0]); end
    end
    testCount++;
    if (busyCyA != 5) begin failCount++; $display("FAIL clear_busy: got %0d want 5", busyCyA); end
    testCount++;
    if (doneCntA != 1) begin failCount++; $display("FAIL clear_done: got %0d want 1", doneCntA); end
    testCount++;
    if (violA != 0) begin failCount++; $display("FAIL clear_stable: got %0d want 0", violA); end
  endtask

  task automatic test_collision;
    clear_mon; pulse_a(1'b1, 1'b1); wait_done_a(50, "collision");
    repeat (30) @(negedge clk);
    testCount++;
    if (capA.size() != 1) begin failCount++; $display("FAIL collision_count: got %0d want 1", capA.size()); end
    else begin
      testCount++;
      if (capA[0] !== 9'h101) begin failCount++; $display("FAIL collision_xfer: got %h want 101", capA[0]); end
    end
  endtask

  task automatic test_ignore_start;
    clear_mon; pulse_a(1'b1, 1'b0);
    repeat (100) @(negedge clk);
    pulse_a(1'b1, 1'b0);
    repeat (50) @(negedge clk);
    pulse_a(1'b0, 1'b1);
    wait_done_a(400, "ignore");
    repeat (30) @(negedge clk);
    testCount++;
    if (capA.size() != N + 2) begin failCount++; $display("FAIL ignore_count: got %0d want %0d", capA.size(), N + 2); end
    testCount++;
    if (doneCntA != 1) begin failCount++; $display("FAIL ignore_done: got %0d want 1", doneCntA); end
    testCount++;
    if (busyCyA != 330) begin failCount++; $display("FAIL ignore_busy: got %0d want 330", busyCyA); end
  endtask

  task automatic test_mid_write;
    logic [3:0] oldV, newV;
    write_a(5, 4'h3);
    clear_mon; pulse_a(1'b1, 1'b0);
    for (int i = 0; i < 100 && capA.size() < 3; i++) begin @(negedge clk); #1; end
    write_a(5, 4'hF);
    for (int i = 0; i < 100 && capA.size() < 9; i++) begin @(negedge clk); #1; end
    // Last HOLD cycle of step 8: the write lands on the edge that enters step 9 SETUP.
    oldV = shadowA[7]; newV = ~oldV;
    @(posedge clk); #1 wrEnA = 1'b1; wrAddrA = 6'd7; wrDataA = newV;
    @(posedge clk); #1 wrEnA = 1'b0;
    wait_done_a(400, "midwrite");
    testCount++;
    if (capA.size() != N + 2) begin failCount++; $display("FAIL midwrite_count: got %0d want %0d", capA.size(), N + 2); end
    else begin
      testCount++;
      if (capA[7] !== 9'h00F) begin failCount++; $display("FAIL midwrite_step7: got %h want 00f", capA[7]); end
      testCount++;
      if (capA[9] !== {5'h0, oldV}) begin failCount++; $display("FAIL samecycle_step9: got %h want %h", capA[9], {5'h0, oldV}); end
    end
    shadowA[7] = newV;
  endtask

  task automatic test_reset_abort;
    clear_mon; pulse_a(1'b1, 1'b0);
    for (int i = 0; i < 200 && !(capA.size() >= 10 && busA.dataEn); i++) begin @(negedge clk); #1; end
    testCount++;
    if (!(capA.size() >= 10 && busA.dataEn)) begin failCount++; $display("FAIL abort_reach_step10: got %0d strobes want 10", capA.size()); end
    reset = 1'b0;
    #1;
    testCount++;
    if ({busA.dataOut, busA.dataEn, busA.rs, busyA, doneA} !== 12'h000) begin
      failCount++; $display("FAIL abort_outputs: got %h want 000", {busA.dataOut, busA.dataEn, busA.rs, busyA, doneA});
    end
    repeat (3) @(negedge clk);
    testCount++;
    if (doneCntA != 0) begin failCount++; $display("FAIL abort_no_done: got %0d want 0", doneCntA); end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < N; i++) shadowA[6'(i)] = 4'h0;
    for (int i = 0; i < NB; i++) shadowB[2'(i)] = 4'h0;
    clear_mon; pulse_a(1'b1, 1'b0); wait_done_a(400, "after_abort");
    testCount++;
    if (capA.size() != N + 2) begin failCount++; $display("FAIL after_abort_count: got %0d want %0d", capA.size(), N + 2); end
    for (int k = 0; k < capA.size() && k < N + 2; k++) begin
      testCount++;
      if (capA[k] !== expA(k)) begin failCount++; $display("FAIL after_abort_xfer%0d: got %h want %h", k, capA[k], expA(k)); end
    end
    testCount++;
    if (doneCntA != 1) begin failCount++; $display("FAIL after_abort_done: got %0d want 1", doneCntA); end
  endtask

  task automatic test_alt_timing;
    int d0;
    for (int i = 0; i < NB; i++) begin
      shadowB[2'(i)] = 4'($urandom_range(0, 15));
      @(posedge clk); #1 wrEnB = 1'b1; wrAddrB = 2'(i); wrDataB = shadowB[2'(i)];
      @(posedge clk); #1 wrEnB = 1'b0;
    end
    clear_mon;
    d0 = doneCntB;
    @(posedge clk); #1 startB = 1'b1;
    @(posedge clk); #1 startB = 1'b0;
    for (int i = 0; i < 100 && doneCntB == d0; i++) begin @(negedge clk); #1; end
    repeat (4) @(negedge clk);
    testCount++;
    if (capB.size() != NB + 2) begin failCount++; $display("FAIL alt_count: got %0d want %0d", capB.size(), NB + 2); end
    for (int k = 0; k < capB.size() && k < NB + 2; k++) begin
      testCount++;
      if (capB[k] !== expB(k)) begin failCount++; $display("FAIL alt_xfer%0d: got %h want %h", k, capB[k], expB(k)); end
      testCount++;
      if (lenB[k] != 1) begin failCount++; $display("FAIL alt_enlen%0d: got %0d want 1", k, lenB[k]); end
    end
    testCount++;
    if (violB != 0) begin failCount++; $display("FAIL alt_hold: got %0d violations want 0", violB); end
    testCount++;
    if (busyCyB != (NB + 2) * 5) begin failCount++; $display("FAIL alt_busy: got %0d want %0d", busyCyB, (NB + 2) * 5); end
    testCount++;
    if (doneCntB != 1) begin failCount++; $display("FAIL alt_done: got %0d want 1", doneCntB); end
  endtask

  initial begin
    test_reset;
    test_plane_zero;
    test_plane_pattern;
    test_random_plane;
    test_clear;
    test_collision;
    test_ignore_start;
    test_mid_write;
    test_reset_abort;
    test_alt_timing;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
